// File: rtl/ram_write_arbiter.sv
// Two-requester RAM write arbiter: grant 1 cycle after request, held until wr_done, then one RELEASE cycle.
// Define RAM_WRITE_ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: requester 0 wins).
module ram_write_arbiter #(
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_wr_request,
  input  logic [ADDR_WIDTH-1:0]   req0_wr_address,
  input  logic [DATA_WIDTH-1:0]   req0_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req0_wr_mask,
  input  logic [BURST_WIDTH-1:0]  req0_wr_burst_length,
  output logic                    req0_wr_done,
  input  logic                    req1_wr_request,
  input  logic [ADDR_WIDTH-1:0]   req1_wr_address,
  input  logic [DATA_WIDTH-1:0]   req1_wr_data,
  input  logic [DATA_WIDTH/8-1:0] req1_wr_mask,
  input  logic [BURST_WIDTH-1:0]  req1_wr_burst_length,
  output logic                    req1_wr_done,
  output logic                    wr_request,
  output logic [ADDR_WIDTH-1:0]   wr_address,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_mask,
  output logic [BURST_WIDTH-1:0]  wr_burst_length,
  input  logic                    wr_done,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic       r_wr_request, w_wr_request_nxt;
  logic [1:0] w_pick;
  logic       w_done_ok;

`ifdef RAM_WRITE_ARBITER_ROUND_ROBIN_EN
  logic r_last, w_last_nxt;

  // r_last: 1 when requester 1 held the most recent grant
  always_comb begin
    w_pick = 2'b00;
    if (req0_wr_request && req1_wr_request) w_pick = r_last ? 2'b01 : 2'b10;
    else if (req0_wr_request)               w_pick = 2'b01;
    else if (req1_wr_request)               w_pick = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last <= 1'b1;
    else       r_last <= w_last_nxt;
  end

  always_comb begin
    w_last_nxt = r_last;
    if (r_state == IDLE && (req0_wr_request || req1_wr_request)) w_last_nxt = w_pick[1];
  end
`else
  always_comb begin
    w_pick = 2'b00;
    if (req0_wr_request)      w_pick = 2'b01;
    else if (req1_wr_request) w_pick = 2'b10;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_wr_request <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_wr_request <= w_wr_request_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_wr_request_nxt = r_wr_request;
    case (r_state)
      IDLE: begin
        if (req0_wr_request || req1_wr_request) begin
          w_grant_nxt      = w_pick;
          w_wr_request_nxt = 1'b1;
          w_state_nxt      = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (wr_done) begin
          w_wr_request_nxt = 1'b0;
          w_state_nxt      = RELEASE;
        end
      end
      RELEASE: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt      = 2'b00;
        w_wr_request_nxt = 1'b0;
        w_state_nxt      = IDLE;
      end
    endcase
  end

  // Completion only counts while the RAM owns a live request
  assign w_done_ok    = wr_done && (r_state == WAIT_DONE);
  assign req0_wr_done = w_done_ok && r_grant[0];
  assign req1_wr_done = w_done_ok && r_grant[1];
  assign wr_request   = r_wr_request;
  assign grant        = r_grant;

  always_comb begin
    wr_address      = '0;
    wr_data         = '0;
    wr_mask         = '0;
    wr_burst_length = '0;
    if (r_grant[0]) begin
      wr_address      = req0_wr_address;
      wr_data         = req0_wr_data;
      wr_mask         = req0_wr_mask;
      wr_burst_length = req0_wr_burst_length;
    end else if (r_grant[1]) begin
      wr_address      = req1_wr_address;
      wr_data         = req1_wr_data;
      wr_mask         = req1_wr_mask;
      wr_burst_length = req1_wr_burst_length;
    end
  end

endmodule
